mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 rst  in  1  synchronous active-high reset.
REQ-003 opcode  in  6  instruction bits [31:26], sampled in DECODE.
REQ-004 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-005 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-006 reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath mux selects.
REQ-007 alu_src_b  out  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2); aluop  out  2  (00 add, 01 sub, 10 funct-decoded).
REQ-008 branch  out  1  and br_sel  out  2  feed the branch-decision gate: 00 none, 01 jump, 10 beq, 11 bgtz.
REQ-009 pc_src  out  2  (00 ALU result, 01 ALUOut, 10 jump target); illegal  out  1  sticky; state  out  4  debug.

Function
REQ-010 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12; state output equals encoding.
REQ-011 All outputs SHALL be Moore (decoded from state only) except the FETCH/MEMRD/MEMWR strobes gated by mem_ready as below.
REQ-012 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00; ir_write and pc_write =1 only when mem_ready=1; stays in FETCH while mem_ready=0, to DECODE when 1.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, aluop=00 (branch target precompute); one cycle; next state by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000111->BRANCH (see REQ-026), 000010->JUMP, 001000->ADDIEX, any other->HALT.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, aluop=00; next MEMRD if lw else MEMWR (opcode held stable by IR).
REQ-015 MEMRD: mem_read=1; waits while mem_ready=0; to MEMWB when 1.
REQ-016 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-017 MEMWR: mem_write=1 held while mem_ready=0; to FETCH when 1.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, aluop=10; next ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01, branch=1, br_sel=10 for beq or 11 for bgtz; next FETCH; pc_write stays 0 (gate output drives conditional PC load).
REQ-020 JUMP: pc_write=1, pc_src=10, branch=0, br_sel=01; next FETCH.
REQ-021 ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-022 HALT: all strobes 0, illegal=1; remains in HALT until rst.
REQ-023 Every non-listed output in a state SHALL be 0; branch=1 only in BRANCH.
REQ-024 Latencies with mem_ready=1 always: R-type/addi 4 cycles, lw 5, sw 4, beq/bgtz 3, j 3.

Reset
REQ-025 rst high at a clock edge SHALL force state=FETCH and illegal=0 next cycle, from any state including mid-wait in MEMRD/MEMWR and HALT; outputs then show FETCH decoding; rst dominates mem_ready.

Configuration
REQ-026 Macro MC_BGTZ_EN: defined -> opcode 000111 decodes to BRANCH with br_sel=11; undefined -> 000111 is illegal and DECODE goes to HALT; br_sel=11 never produced.

Verification
REQ-027 rst=1 one cycle, mem_ready=1 -> state=0, mem_read=1, pc_write=1, ir_write=1, illegal=0.
REQ-028 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-029 sw with mem_ready low 3 cycles in MEMWR -> state=5 for 4 cycles, mem_write=1 throughout, then state=0.
REQ-030 beq (000100) -> states 0,1,8,0; in state 8 branch=1, br_sel=10, aluop=01, pc_write=0; j (000010) -> state 9 with pc_write=1, pc_src=10, br_sel=01.
REQ-031 opcode 000111 with MC_BGTZ_EN -> state 8, br_sel=11; without -> state 12, illegal=1 until rst.
REQ-032 rst asserted while state=3 with mem_ready=0 -> next cycle state=0, mem_read=1, no reg_write pulse.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-style control unit.
// The unit sequences instruction fetch, decode, memory access, ALU,
// branch, jump and addi through a Moore FSM. The FETCH, MEMRD and MEMWR
// states wait on the mem_ready handshake.
// Optional feature: define MC_BGTZ_EN to decode opcode 000111 (bgtz) as a
// branch with br_sel=11. When the macro is undefined, that opcode is
// illegal and the FSM halts.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       branch,
    output logic [1:0] br_sel,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // State and sticky illegal flag; reset returns to FETCH from anywhere, HALT included
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and per-state output decode, every output defaulted to 0 first
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        branch     = 1'b0;
        br_sel     = 2'b00;
        pc_src     = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BRANCH;
`ifdef MC_BGTZ_EN
                    OP_BGTZ:       state_d = BRANCH;
`endif
                    OP_J:          state_d = JUMP;
                    OP_ADDI:       state_d = ADDIEX;
                    default:       state_d = HALT;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
`ifdef MC_BGTZ_EN
                br_sel    = (opcode == OP_BGTZ) ? 2'b11 : 2'b10;
`else
                br_sel    = 2'b10;
`endif
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                br_sel   = 2'b01;
                state_d  = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        illegal_d = illegal_q | (state_d == HALT);
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: directed instruction sequences.
// The stimulus process pushes the expected output vector for each cycle into a
// scoreboard queue. A monitor process pops that vector at the falling edge and
// compares it against the DUT outputs.
// The bench follows the DUT build: define MC_BGTZ_EN for both or for neither.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       branch;
        logic [1:0] br_sel;
        logic [1:0] pc_src;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, branch, illegal;
    logic [1:0] alu_src_b, aluop, br_sel, pc_src;
    logic [3:0] state;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluop(aluop), .branch(branch), .br_sel(br_sel), .pc_src(pc_src),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle: the hand-written decode table for each state
    function automatic out_t expOut(input logic [3:0] st, input logic mr, input logic [5:0] op);
        out_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.pc_write = mr; e.ir_write = mr; end
            4'd1:  e.alu_src_b = 2'b11;
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  e.mem_read = 1;
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            4'd5:  e.mem_write = 1;
            4'd6:  begin e.alu_src_a = 1; e.aluop = 2'b10; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
            4'd8:  begin
                       e.alu_src_a = 1; e.aluop = 2'b01; e.pc_src = 2'b01; e.branch = 1;
                       e.br_sel = (op == OP_BGTZ) ? 2'b11 : 2'b10;
                   end
            4'd9:  begin e.pc_write = 1; e.pc_src = 2'b10; e.br_sel = 2'b01; end
            4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd11: e.reg_write = 1;
            4'd12: e.illegal = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the expected response
    task automatic applyStimulus(input logic r, input logic mr, input logic [5:0] op,
                                 input logic [3:0] exp_st, input logic do_check, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = mr;
        opcode    = op;
        if (do_check) begin
            exp_q.push_back(expOut(exp_st, mr, op));
            name_q.push_back(nm);
        end
    endtask

    // Compare one sampled output vector against the expected vector
    task automatic checkOutput(input out_t exp, input string nm);
        out_t act;
        act = {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, aluop, branch, br_sel, pc_src, illegal};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare at the falling edge of every cycle that has a queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    // Watchdog bounds the run regardless of stimulus
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed instruction sequences
    initial begin
        applyStimulus(1, 1, OP_LW, 4'd0, 0, "reset");
        // lw: 0,1,2,3,4,0
        applyStimulus(0, 1, OP_LW, 4'd0, 1, "rst_fetch");
        applyStimulus(0, 1, OP_LW, 4'd1, 1, "lw_decode");
        applyStimulus(0, 1, OP_LW, 4'd2, 1, "lw_memadr");
        applyStimulus(0, 1, OP_LW, 4'd3, 1, "lw_memrd");
        applyStimulus(0, 1, OP_LW, 4'd4, 1, "lw_memwb");
        // FETCH stall, then sw with mem_ready low for 3 cycles in MEMWR
        applyStimulus(0, 0, OP_SW, 4'd0, 1, "fetch_wait");
        applyStimulus(0, 1, OP_SW, 4'd0, 1, "sw_fetch");
        applyStimulus(0, 1, OP_SW, 4'd1, 1, "sw_decode");
        applyStimulus(0, 1, OP_SW, 4'd2, 1, "sw_memadr");
        applyStimulus(0, 0, OP_SW, 4'd5, 1, "sw_wait1");
        applyStimulus(0, 0, OP_SW, 4'd5, 1, "sw_wait2");
        applyStimulus(0, 0, OP_SW, 4'd5, 1, "sw_wait3");
        applyStimulus(0, 1, OP_SW, 4'd5, 1, "sw_done");
        // beq: 0,1,8
        applyStimulus(0, 1, OP_BEQ, 4'd0, 1, "beq_fetch");
        applyStimulus(0, 1, OP_BEQ, 4'd1, 1, "beq_decode");
        applyStimulus(0, 1, OP_BEQ, 4'd8, 1, "beq_branch");
        // j: 0,1,9
        applyStimulus(0, 1, OP_J, 4'd0, 1, "j_fetch");
        applyStimulus(0, 1, OP_J, 4'd1, 1, "j_decode");
        applyStimulus(0, 1, OP_J, 4'd9, 1, "j_jump");
        // R-type: 0,1,6,7
        applyStimulus(0, 1, OP_R, 4'd0, 1, "r_fetch");
        applyStimulus(0, 1, OP_R, 4'd1, 1, "r_decode");
        applyStimulus(0, 1, OP_R, 4'd6, 1, "r_exec");
        applyStimulus(0, 1, OP_R, 4'd7, 1, "r_aluwb");
        // addi: 0,1,10,11
        applyStimulus(0, 1, OP_ADDI, 4'd0, 1, "addi_fetch");
        applyStimulus(0, 1, OP_ADDI, 4'd1, 1, "addi_decode");
        applyStimulus(0, 1, OP_ADDI, 4'd10, 1, "addi_ex");
        applyStimulus(0, 1, OP_ADDI, 4'd11, 1, "addi_wb");
        // bgtz: branch when enabled, halt when not
        applyStimulus(0, 1, OP_BGTZ, 4'd0, 1, "bgtz_fetch");
        applyStimulus(0, 1, OP_BGTZ, 4'd1, 1, "bgtz_decode");
`ifdef MC_BGTZ_EN
        applyStimulus(0, 1, OP_BGTZ, 4'd8, 1, "bgtz_branch");
        applyStimulus(0, 1, OP_BAD, 4'd0, 1, "bad_fetch");
`else
        applyStimulus(0, 1, OP_BGTZ, 4'd12, 1, "bgtz_halt");
        applyStimulus(0, 0, OP_BGTZ, 4'd12, 1, "bgtz_halt_hold");
        applyStimulus(1, 1, OP_BAD, 4'd12, 1, "bgtz_halt_rst");
        applyStimulus(0, 1, OP_BAD, 4'd0, 1, "bad_fetch");
`endif
        // undefined opcode: HALT is sticky until reset, then FETCH again
        applyStimulus(0, 1, OP_BAD, 4'd1, 1, "bad_decode");
        applyStimulus(0, 1, OP_BAD, 4'd12, 1, "halt1");
        applyStimulus(0, 0, OP_LW, 4'd12, 1, "halt2");
        applyStimulus(0, 1, OP_R, 4'd12, 1, "halt3");
        applyStimulus(1, 1, OP_LW, 4'd12, 1, "halt_rst");
        // reset during MEMRD wait with mem_ready low: straight to FETCH, no writeback
        applyStimulus(0, 1, OP_LW, 4'd0, 1, "post_halt_fetch");
        applyStimulus(0, 1, OP_LW, 4'd1, 1, "lw2_decode");
        applyStimulus(0, 1, OP_LW, 4'd2, 1, "lw2_memadr");
        applyStimulus(0, 0, OP_LW, 4'd3, 1, "lw2_memrd_wait");
        applyStimulus(1, 0, OP_LW, 4'd3, 1, "lw2_memrd_rst");
        applyStimulus(0, 0, OP_LW, 4'd0, 1, "memrd_rst_fetch");
        applyStimulus(0, 1, OP_LW, 4'd0, 1, "memrd_rst_fetch2");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
